// File: rtl/ip_rewrite_tile_ctrl_resp.sv
`default_nettype none
// ============================================================================
// Module   : ip_rewrite_tile_ctrl_resp
// Brief    : Rewrite-notification responder: accepts header+body from the NoC,
//            commits the entry to the rewrite table, returns a one-flit ack.
// Revision : 1.0 - initial release
// ============================================================================
module ip_rewrite_tile_ctrl_resp #(
    parameter int NOC_DATA_W  = 512,
    parameter int NUM_ENTRIES = 1024,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  noc_in_val,
    input  logic [NOC_DATA_W-1:0] noc_in_data,
    output logic                  noc_in_rdy,
    output logic                  noc_out_val,
    output logic [NOC_DATA_W-1:0] noc_out_data,
    input  logic                  noc_out_rdy,
    output logic                  tbl_wr_val,
    output logic [IDX_W-1:0]      tbl_wr_idx,
    output logic [31:0]           tbl_wr_ip,
    output logic                  tbl_wr_en,
    input  logic                  tbl_wr_rdy,
    output logic [31:0]           upd_cnt,
    output logic [15:0]           err_cnt
);

    localparam logic [7:0] c_rewrite_notif = 8'h20;
    localparam logic [7:0] c_ack_type      = 8'h21;

    typedef enum logic [2:0] {
        S_WAIT_HDR  = 3'd0,
        S_DROP_BODY = 3'd1,
        S_WAIT_BODY = 3'd2,
        S_WRITE_TBL = 3'd3,
        S_SEND_ACK  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        alive_q, alive_d;
    logic [7:0]  src_x_q, src_x_d;
    logic [7:0]  src_y_q, src_y_d;
    logic [3:0]  src_f_q, src_f_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] ip_q, ip_d;
    logic        en_q, en_d;
    logic        status_q, status_d;
    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        w_in_hs;
    logic        w_idx_ok;
    logic        w_in_state;

    // alive_q keeps noc_in_rdy low until the first edge after reset release
    assign w_in_state = (state_q == S_WAIT_HDR) || (state_q == S_DROP_BODY) ||
                        (state_q == S_WAIT_BODY);
    assign noc_in_rdy  = alive_q & w_in_state;
    assign tbl_wr_val  = (state_q == S_WRITE_TBL);
    assign noc_out_val = (state_q == S_SEND_ACK);
    assign w_in_hs     = noc_in_val & noc_in_rdy;
    assign w_idx_ok    = (32'(noc_in_data[15:0]) < 32'(NUM_ENTRIES));

    always_comb begin
        state_d   = state_q;
        alive_d   = 1'b1;
        src_x_d   = src_x_q;
        src_y_d   = src_y_q;
        src_f_d   = src_f_q;
        idx_d     = idx_q;
        ip_d      = ip_q;
        en_d      = en_q;
        status_d  = status_q;
        upd_cnt_d = upd_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_WAIT_HDR: begin
                if (w_in_hs) begin
                    src_x_d = noc_in_data[15:8];
                    src_y_d = noc_in_data[23:16];
                    src_f_d = noc_in_data[27:24];
                    if (noc_in_data[7:0] == c_rewrite_notif) begin
                        state_d = S_WAIT_BODY;
                    end else begin
                        state_d   = S_DROP_BODY;
                        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
                    end
                end
            end
            S_DROP_BODY: begin
                if (w_in_hs) begin
                    state_d = S_WAIT_HDR;
                end
            end
            S_WAIT_BODY: begin
                if (w_in_hs) begin
                    idx_d = noc_in_data[15:0];
                    ip_d  = noc_in_data[47:16];
                    en_d  = noc_in_data[48];
                    if (w_idx_ok) begin
                        state_d = S_WRITE_TBL;
                    end else begin
                        status_d  = 1'b0;
                        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
                        state_d   = S_SEND_ACK;
                    end
                end
            end
            S_WRITE_TBL: begin
                if (tbl_wr_rdy) begin
                    status_d = 1'b1;
                    state_d  = S_SEND_ACK;
                end
            end
            S_SEND_ACK: begin
                if (noc_out_rdy) begin
                    state_d = S_WAIT_HDR;
                    if (status_q) begin
                        upd_cnt_d = (upd_cnt_q == '1) ? upd_cnt_q : upd_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = S_WAIT_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_HDR;
            alive_q   <= 1'b0;
            src_x_q   <= 8'd0;
            src_y_q   <= 8'd0;
            src_f_q   <= 4'd0;
            idx_q     <= 16'd0;
            ip_q      <= 32'd0;
            en_q      <= 1'b0;
            status_q  <= 1'b0;
            upd_cnt_q <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            src_x_q   <= src_x_d;
            src_y_q   <= src_y_d;
            src_f_q   <= src_f_d;
            idx_q     <= idx_d;
            ip_q      <= ip_d;
            en_q      <= en_d;
            status_q  <= status_d;
            upd_cnt_q <= upd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    logic [IDX_W-1:0] w_idx_trunc;

    generate
        if (IDX_W < 16) begin : g_idx_narrow
            logic unused_idx_hi;
            assign w_idx_trunc   = idx_q[IDX_W-1:0];
            assign unused_idx_hi = ^idx_q[15:IDX_W];
        end else if (IDX_W == 16) begin : g_idx_exact
            assign w_idx_trunc = idx_q;
        end else begin : g_idx_wide
            assign w_idx_trunc = {{(IDX_W-16){1'b0}}, idx_q};
        end
    endgenerate

    // Data outputs read as zero outside their valid state so reset shows all-zero
    assign tbl_wr_idx = tbl_wr_val ? w_idx_trunc : '0;
    assign tbl_wr_ip  = tbl_wr_val ? ip_q : 32'd0;
    assign tbl_wr_en  = tbl_wr_val & en_q;

    always_comb begin
        noc_out_data = '0;
        if (state_q == S_SEND_ACK) begin
            noc_out_data[7:0]   = c_ack_type;
            noc_out_data[15:8]  = src_x_q;
            noc_out_data[23:16] = src_y_q;
            noc_out_data[27:24] = src_f_q;
            noc_out_data[28]    = status_q;
        end
    end

    assign upd_cnt = upd_cnt_q;
    assign err_cnt = err_cnt_q;

    logic unused_in_hi;
    assign unused_in_hi = ^noc_in_data[NOC_DATA_W-1:49];

endmodule
`default_nettype wire
